// File: rtl/divider_restoring_seq_pkg.sv
// rtl/divider_restoring_seq_pkg.sv - shared FSM encodings and sizing helper for the restoring divider
package divider_restoring_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  function automatic int div_cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divider_restoring_seq_divider_step.sv
// rtl/divider_restoring_seq_divider_step.sv - one combinational restoring-division step
module divider_step #(
  parameter int width = 8
) (
  input  logic [width-1:0] rem_i,
  input  logic             bit_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] rem_o,
  output logic             qbit_o
);

  logic [width:0] t;

  // t >= b guarantees the difference fits in width bits, so the low-bit subtract is exact
  always_comb begin
    t = {rem_i, bit_i};
    if (t >= {1'b0, b_i}) begin
      rem_o  = t[width-1:0] - b_i;
      qbit_o = 1'b1;
    end else begin
      rem_o  = t[width-1:0];
      qbit_o = 1'b0;
    end
  end

endmodule

// File: rtl/divider_restoring_seq.sv
// rtl/divider_restoring_seq.sv - sequential unsigned restoring divider, one quotient bit per cycle
module divider_restoring_seq
  import divider_restoring_seq_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             dbz
);

  localparam int cnt_w = div_cnt_width(width);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(width - 1);

  div_state_t       state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [width-1:0] a_sh_q, a_sh_d;
  logic [width-1:0] b_q, b_d;
  logic [width-1:0] qacc_q, qacc_d;
  logic [width-1:0] rem_q, rem_d;
  logic [width-1:0] q_q, q_d;
  logic [width-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [width-1:0] step_rem;
  logic             step_qbit;
  logic [width-1:0] qacc_next;

  divider_step #(.width(width)) u_step (
    .rem_i (rem_q),
    .bit_i (a_sh_q[width-1]),
    .b_i   (b_q),
    .rem_o (step_rem),
    .qbit_o(step_qbit)
  );

  assign qacc_next = (qacc_q << 1) | width'(step_qbit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_d     = b_q;
    qacc_d  = qacc_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_d     = b;
          cnt_d   = cnt_last;
          rem_d   = '0;
          qacc_d  = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q << 1;
        rem_d  = step_rem;
        qacc_d = qacc_next;
        cnt_d  = cnt_q - cnt_w'(1);
        busy_d = 1'b1;
        // Results are published only on the final step so q/r never show partial values
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          q_d     = qacc_next;
          r_d     = step_rem;
          dbz_d   = (b_q == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_q     <= '0;
      qacc_q  <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_q     <= b_d;
      qacc_q  <= qacc_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_divider_restoring_seq.sv
// tb/tb_divider_restoring_seq.sv - randomized self-checking bench for divider_restoring_seq
module tb_divider_restoring_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] r;
  logic       dbz;

  int total = 0;
  int bad   = 0;

  divider_restoring_seq #(.width(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  // Cycle count is relative to the cycle in which start is sampled; done is expected in cycle 9
  task automatic run_div(input logic [7:0] aa, input logic [7:0] bb,
                         output int lat, output int busy_n, output int unstable,
                         output logic [7:0] qq, output logic [7:0] rr, output logic dd);
    logic [7:0] q0, r0;
    logic       d0;
    logic       got;
    @(negedge clk);
    q0 = q; r0 = r; d0 = dbz;
    a = aa; b = bb; start = 1'b1;
    lat = 0; busy_n = 0; unstable = 0; qq = '0; rr = '0; dd = 1'b0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      lat++;
      if (busy) busy_n++;
      if (done) begin
        qq = q; rr = r; dd = dbz; got = 1'b1;
      end else if (q !== q0 || r !== r0 || dbz !== d0) begin
        unstable++;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL timeout: no done within %0d cycles for a=%0d b=%0d", lat, aa, bb);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, dbz, q, r} !== 19'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%0b done=%0b dbz=%0b q=%0d r=%0d required all 0", busy, done, dbz, q, r);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bn, un;
    logic [7:0] qq, rr;
    logic dd;
    run_div(8'd100, 8'd7, lat, bn, un, qq, rr, dd);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL basic_latency: got %0d required 9", lat); end
    total++;
    if (bn !== 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d required 8", bn); end
    total++;
    if (qq !== 8'd14 || rr !== 8'd2 || dd !== 1'b0) begin
      bad++; $display("FAIL basic_result: q=%0d r=%0d dbz=%0b required 14 2 0", qq, rr, dd);
    end
    total++;
    if (un !== 0) begin bad++; $display("FAIL basic_hold: %0d changes before done, required 0", un); end
  endtask

  task automatic test_corners;
    logic [7:0] ta [5] = '{8'd255, 8'd5, 8'd0, 8'd255, 8'd0};
    logic [7:0] tb [5] = '{8'd1,   8'd9, 8'd3, 8'd255, 8'd255};
    int lat, bn, un;
    logic [7:0] qq, rr;
    logic dd;
    for (int i = 0; i < 5; i++) begin
      run_div(ta[i], tb[i], lat, bn, un, qq, rr, dd);
      total++;
      if (qq !== ta[i] / tb[i] || rr !== ta[i] % tb[i] || dd !== 1'b0) begin
        bad++;
        $display("FAIL corner_%0d: %0d/%0d gave q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=0",
                 i, ta[i], tb[i], qq, rr, dd, ta[i] / tb[i], ta[i] % tb[i]);
      end
    end
  endtask

  task automatic test_dbz;
    int lat, bn, un;
    logic [7:0] qq, rr;
    logic dd;
    run_div(8'd77, 8'd0, lat, bn, un, qq, rr, dd);
    total++;
    if (qq !== 8'd255 || rr !== 8'd77 || dd !== 1'b1) begin
      bad++; $display("FAIL dbz_result: q=%0d r=%0d dbz=%0b required 255 77 1", qq, rr, dd);
    end
    total++;
    if (lat !== 9 || bn !== 8) begin
      bad++; $display("FAIL dbz_latency: lat=%0d busy=%0d required 9 8", lat, bn);
    end
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    int done_at [$];
    logic [7:0] qs [$];
    logic [7:0] rs [$];
    int busy_in_done = 0;
    @(negedge clk);
    a = 8'd100; b = 8'd7; start = 1'b1;
    while (done_at.size() < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      // new operands appear during RUN and must be ignored until the DONE cycle
      a = 8'd200; b = 8'd13;
      if (done) begin
        done_at.push_back(cyc); qs.push_back(q); rs.push_back(r);
        if (busy) busy_in_done++;
      end
    end
    start = 1'b0;
    total++;
    if (done_at.size() != 2) begin
      bad++; $display("FAIL b2b_count: got %0d done pulses required 2", done_at.size());
    end else begin
      total++;
      if (done_at[0] != 9 || done_at[1] != 18) begin
        bad++; $display("FAIL b2b_timing: done at %0d,%0d required 9,18", done_at[0], done_at[1]);
      end
      total++;
      if (qs[0] !== 8'd14 || rs[0] !== 8'd2) begin
        bad++; $display("FAIL b2b_first: q=%0d r=%0d required 14 2", qs[0], rs[0]);
      end
      total++;
      if (qs[1] !== 8'd15 || rs[1] !== 8'd5) begin
        bad++; $display("FAIL b2b_second: q=%0d r=%0d required 15 5", qs[1], rs[1]);
      end
    end
    total++;
    if (busy_in_done != 0) begin
      bad++; $display("FAIL b2b_busy_in_done: got %0d required 0", busy_in_done);
    end
  endtask

  task automatic test_abort;
    int lat, bn, un;
    int stray = 0;
    logic [7:0] qq, rr;
    logic dd;
    @(negedge clk);
    a = 8'd100; b = 8'd7; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || q !== 8'd0 || r !== 8'd0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_state: busy=%0b done=%0b q=%0d r=%0d required 0 0 0 0", busy, done, q, r);
    end
    rst = 1'b0; start = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses required 0", stray); end
    run_div(8'd200, 8'd13, lat, bn, un, qq, rr, dd);
    total++;
    if (qq !== 8'd15 || rr !== 8'd5 || lat !== 9) begin
      bad++; $display("FAIL abort_recover: q=%0d r=%0d lat=%0d required 15 5 9", qq, rr, lat);
    end
  endtask

  task automatic test_random;
    int lat, bn, un;
    logic [7:0] qq, rr;
    logic dd;
    logic [7:0] ra, rb;
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom_range(1, 255));
      run_div(ra, rb, lat, bn, un, qq, rr, dd);
      total++;
      if (int'(qq) * int'(rb) + int'(rr) != int'(ra) || rr >= rb || qq !== ra / rb || dd !== 1'b0) begin
        bad++;
        $display("FAIL random_%0d: %0d/%0d gave q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=0",
                 i, ra, rb, qq, rr, dd, ra / rb, ra % rb);
      end
      total++;
      if (un != 0 || lat != 9) begin
        bad++; $display("FAIL random_timing_%0d: changes=%0d lat=%0d required 0 9", i, un, lat);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset;
    test_basic;
    test_corners;
    test_dbz;
    test_back_to_back;
    test_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
